// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staggered board reset sequencer driven by PLL lock, DDR calibration and soft requests
module rst_seq_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DDR_EN             = 1,
  parameter int DDR_RST_CYCLES     = 200,
  parameter int CALIB_TIMEOUT      = 1048576,
  parameter int HOLD_CYCLES        = 100,
  parameter int STAGGER_CYCLES     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       ddr_calib_done_i,
  input  logic       soft_rst_req_i,
  output logic       rst_sys_o,
  output logic       ddr_rst_o,
  output logic       ftdi_rst_n_o,
  output logic       dpti_rst_o,
  output logic       uart_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);
  localparam logic [2:0] S_RESET      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_DDR_RST    = 3'd2;
  localparam logic [2:0] S_WAIT_CALIB = 3'd3;
  localparam logic [2:0] S_HOLD       = 3'd4;
  localparam logic [2:0] S_RELEASE    = 3'd5;
  localparam logic [2:0] S_RUN        = 3'd6;
  localparam logic [2:0] S_FAULT      = 3'd7;
  localparam logic [23:0] LOCK_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
  localparam logic [23:0] DDR_LAST   = 24'(DDR_RST_CYCLES - 1);
  localparam logic [23:0] CALIB_LAST = 24'(CALIB_TIMEOUT - 1);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYCLES - 1);
  // stagger thresholds are wider than the counter so 3*STAGGER_CYCLES cannot overflow
  localparam logic [25:0] STG1     = 26'(STAGGER_CYCLES);
  localparam logic [25:0] STG2     = 26'(2 * STAGGER_CYCLES);
  localparam logic [25:0] STG_LAST = 26'(3 * STAGGER_CYCLES - 1);
  localparam logic [2:0] S_AFTER_LOCK = (DDR_EN != 0) ? S_DDR_RST : S_HOLD;
  logic [2:0]  state, ns;
  logic [23:0] cnt, ncnt;
  logic        soft_prev, soft_rise, rel, run;
  assign soft_rise = soft_rst_req_i && !soft_prev;
  assign state_o = state;
  // next state: lock loss overrides soft requests, which override normal sequencing
  always_comb begin
    ns = state;
    case (state)
      S_RESET:      ns = S_WAIT_LOCK;
      S_WAIT_LOCK:  ns = (pll_locked_i && cnt == LOCK_LAST) ? S_AFTER_LOCK : state;
      S_DDR_RST:    ns = (cnt == DDR_LAST) ? S_WAIT_CALIB : state;
      S_WAIT_CALIB: ns = ddr_calib_done_i ? S_HOLD : (cnt == CALIB_LAST) ? S_FAULT : state;
      S_HOLD:       ns = (cnt == HOLD_LAST) ? S_RELEASE : state;
      S_RELEASE:    ns = ({2'b00, cnt} == STG_LAST) ? S_RUN : state;
      S_RUN:        ns = soft_rise ? S_HOLD : state;
      default:      ns = soft_rise ? S_AFTER_LOCK : state;
    endcase
    if (!pll_locked_i && state >= S_DDR_RST) ns = S_WAIT_LOCK;
  end
  // counter restarts on every state change and on any low lock sample while waiting for lock
  assign ncnt = (ns != state || (state == S_WAIT_LOCK && !pll_locked_i)) ? '0 : cnt + 24'd1;
  assign rel = ns == S_RELEASE;
  assign run = ns == S_RUN;
  // outputs are registered from next state/count so they line up with state_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_RESET;
      cnt          <= '0;
      soft_prev    <= 1'b0;
      rst_sys_o    <= 1'b1;
      ddr_rst_o    <= 1'b1;
      ftdi_rst_n_o <= 1'b0;
      dpti_rst_o   <= 1'b1;
      uart_rst_o   <= 1'b1;
      ready_o      <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      state        <= ns;
      cnt          <= ncnt;
      soft_prev    <= soft_rst_req_i;
      rst_sys_o    <= !(rel || run);
      ddr_rst_o    <= (DDR_EN == 0) || (ns inside {S_RESET, S_WAIT_LOCK, S_DDR_RST, S_FAULT});
      ftdi_rst_n_o <= run || (rel && {2'b00, ncnt} >= STG1);
      dpti_rst_o   <= !(run || (rel && {2'b00, ncnt} >= STG2));
      uart_rst_o   <= !run;
      ready_o      <= run;
      fault_o      <= ns == S_FAULT;
    end
  end
endmodule
